// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and sizing constants for the reservation-station issue logic
package rs_pkg;
    localparam int RS_ROW_COUNT    = 64;
    localparam int ROB_BITS        = 6;
    localparam int RS_IDX_W        = $clog2(RS_ROW_COUNT);
    localparam int NUM_FU          = 3;
    localparam int ALU_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_LSU  = 2'd2,
        FU_NONE = 2'd3
    } fu_id_t;

    typedef enum logic {
        FU_IDLE = 1'b0,
        FU_BUSY = 1'b1
    } fu_state_t;
endpackage

// File: rtl/rs_issue_scheduler_select.sv
// rtl/rs_issue_scheduler_select.sv - oldest-first priority picker over a masked row set
module rs_oldest_select #(
    parameter int N  = 64,
    parameter int AW = 6,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]    i_mask,
    input  logic [N*AW-1:0] i_age,
    output logic            o_valid,
    output logic [IW-1:0]   o_idx
);
    logic          w_found;
    logic [IW-1:0] w_idx;
    logic [AW-1:0] w_best;

    // Strict less-than keeps the lower row index on equal ages.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_best  = '0;
        for (int i = 0; i < N; i++) begin
            if (i_mask[i] && (!w_found || (i_age[i*AW +: AW] < w_best))) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
                w_best  = i_age[i*AW +: AW];
            end
        end
    end

    assign o_valid = w_found;
    assign o_idx   = w_idx;
endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - per-FU oldest-ready issue select with ALU/LSU occupancy tracking
module rs_issue_scheduler #(
    parameter int RS_ROW_COUNT = rs_pkg::RS_ROW_COUNT,
    parameter int ROB_BITS     = rs_pkg::ROB_BITS,
    parameter int ALU_LAT      = rs_pkg::ALU_LAT_DEFAULT,
    localparam int IDX_W       = $clog2(RS_ROW_COUNT)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RS_ROW_COUNT-1:0]      req_valid,
    input  logic [2*RS_ROW_COUNT-1:0]    req_fu,
    input  logic [ROB_BITS*RS_ROW_COUNT-1:0] req_rob,
    input  logic [ROB_BITS-1:0]          rob_head,
    input  logic                         flush,
    input  logic                         lsu_done,
    output logic [2:0]                   issue_valid,
    output logic [3*IDX_W-1:0]           issue_row,
    output logic [2:0]                   fu_ready
);
    import rs_pkg::*;

    logic [2:0]                      r_issue_valid;
    logic [3*IDX_W-1:0]              r_issue_row;
    logic [1:0][3:0]                 r_alu_cnt;
    fu_state_t                       r_lsu_state;

    logic [RS_ROW_COUNT-1:0]         w_last_grant;
    logic [ROB_BITS*RS_ROW_COUNT-1:0] w_age;
    logic [2:0][RS_ROW_COUNT-1:0]    w_mask;
    logic [2:0]                      w_sel_valid;
    logic [2:0][IDX_W-1:0]           w_sel_idx;

    assign issue_valid = r_issue_valid;
    assign issue_row   = r_issue_row;
    assign fu_ready    = {r_lsu_state == FU_IDLE, r_alu_cnt[1] == 4'd0, r_alu_cnt[0] == 4'd0};

    // Rows granted last edge are still marked valid by the RS for one more cycle.
    always_comb begin
        w_last_grant = '0;
        for (int f = 0; f < 3; f++) begin
            if (r_issue_valid[f]) begin
                w_last_grant[r_issue_row[f*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_age  = '0;
        w_mask = '0;
        for (int i = 0; i < RS_ROW_COUNT; i++) begin
            w_age[i*ROB_BITS +: ROB_BITS] = req_rob[i*ROB_BITS +: ROB_BITS] - rob_head;
            for (int f = 0; f < 3; f++) begin
                w_mask[f][i] = req_valid[i] && (req_fu[2*i +: 2] == 2'(f)) && fu_ready[f]
                               && !flush && !w_last_grant[i];
            end
        end
    end

    for (genvar f = 0; f < 3; f++) begin : g_sel
        rs_oldest_select #(
            .N  (RS_ROW_COUNT),
            .AW (ROB_BITS),
            .IW (IDX_W)
        ) u_sel (
            .i_mask  (w_mask[f]),
            .i_age   (w_age),
            .o_valid (w_sel_valid[f]),
            .o_idx   (w_sel_idx[f])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_issue_valid <= '0;
            r_issue_row   <= '0;
            r_alu_cnt     <= '0;
            r_lsu_state   <= FU_IDLE;
        end else begin
            r_issue_valid <= w_sel_valid;
            for (int f = 0; f < 3; f++) begin
                if (w_sel_valid[f]) begin
                    r_issue_row[f*IDX_W +: IDX_W] <= w_sel_idx[f];
                end
            end
            for (int a = 0; a < 2; a++) begin
                if (flush) begin
                    r_alu_cnt[a] <= 4'd0;
                end else if (w_sel_valid[a]) begin
                    r_alu_cnt[a] <= 4'(ALU_LAT);
                end else if (r_alu_cnt[a] != 4'd0) begin
                    r_alu_cnt[a] <= r_alu_cnt[a] - 4'd1;
                end
            end
            // An in-flight memory op survives flush; only lsu_done releases the LSU.
            case (r_lsu_state)
                FU_IDLE: if (w_sel_valid[2]) r_lsu_state <= FU_BUSY;
                FU_BUSY: if (lsu_done)       r_lsu_state <= FU_IDLE;
                default:                     r_lsu_state <= FU_IDLE;
            endcase
        end
    end
endmodule
